// File: rtl/gray_counter_source.sv
// Gray-code sequence source with a valid/ready handshake, up/down counting,
// synchronous clear and Gray-coded preload. All outputs come straight from registers.
module gray_counter_source #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic             out_valid,
  output logic             wrap
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] g_reg, g_next;
  logic             wrap_reg, wrap_next;
  // Remembers whether bin_reg was last reached by wrapping, so a code presented
  // after an IDLE gap still carries its wrap marker.
  logic             wrapped_reg, wrapped_next;
  logic [WIDTH-1:0] load_bin, adv_bin;
  logic             adv_wrap;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign load_bin[gi] = ^load_gray[WIDTH-1:gi];
    end
  endgenerate

  assign adv_bin  = up ? bin_reg + WIDTH'(1) : bin_reg - WIDTH'(1);
  assign adv_wrap = up ? (bin_reg == {WIDTH{1'b1}}) : (bin_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      g_reg       <= '0;
      wrap_reg    <= 1'b0;
      wrapped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bin_reg     <= bin_next;
      g_reg       <= g_next;
      wrap_reg    <= wrap_next;
      wrapped_reg <= wrapped_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bin_next     = bin_reg;
    g_next       = g_reg;
    wrap_next    = wrap_reg;
    wrapped_next = wrapped_reg;
    if (clr) begin
      state_next   = IDLE;
      bin_next     = '0;
      g_next       = '0;
      wrap_next    = 1'b0;
      wrapped_next = 1'b0;
    end else if (load) begin
      // Flushes any pending code, even under backpressure.
      state_next   = IDLE;
      bin_next     = load_bin;
      wrap_next    = 1'b0;
      wrapped_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_next = PRESENT;
            g_next     = to_gray(bin_reg);
            wrap_next  = wrapped_reg;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            bin_next     = adv_bin;
            wrapped_next = adv_wrap;
            if (en) begin
              g_next    = to_gray(adv_bin);
              wrap_next = adv_wrap;
            end else begin
              state_next = IDLE;
              wrap_next  = 1'b0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign g_out     = g_reg;
  assign out_valid = (state_reg == PRESENT);
  assign wrap      = wrap_reg;

endmodule
